seg7_scan_driver: RTL and testbench

- Multiplexed hex seven-segment display driver, downstream of the 1 kHz scan-clock divider.
- Samples the divided scan clock in the system clk domain and advances one digit per scan-clock rising edge.
- Latches display data once per frame and drives anode and segment lines, with per-digit blanking, decimal points and leading-zero suppression.

---
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex seven-segment scan driver
//
// Purpose: samples the divided scan clock in the clk domain and advances one
// digit per scan_clk rising edge. A shadow copy of data/dp/blank/lz_suppress
// is taken at each frame start, so a frame always shows a consistent value.
// Outputs are registered. They are driven unlit until the first scan tick.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   scan_clk     divided scan clock, asynchronous to clk
//   data         hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp           decimal point request per digit
//   blank        1 = digit fully dark
//   lz_suppress  1 = suppress leading zeros (digit 0 is never suppressed)
//   an           digit select, polarity per AN_ACTIVE_LOW
//   seg          segments a..g in seg[0]..seg[6], polarity per SEG_ACTIVE_LOW
//   seg_dp       decimal point segment, polarity per SEG_ACTIVE_LOW
//   frame_start  one-clk pulse when a new frame is latched
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic                  frame_start
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  // "Off" levels in pin polarity; XOR with these converts active-high to pin form.
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan clock synchronizer plus history flop for rising-edge detection.
  logic sync1_q, sync2_q, hist_q;
  logic tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= scan_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~hist_q;

  // Sequencer state and frame shadow.
  logic                started_q, started_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_start_q, frame_start_d;
  logic                load;
  logic [4*DIGITS-1:0] data_sh_q;
  logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                lz_sh_q;

  always_comb begin
    started_d     = started_q;
    idx_d         = idx_q;
    frame_start_d = 1'b0;
    load          = 1'b0;
    if (tick) begin
      if (!started_q || idx_q == LAST) begin
        started_d     = 1'b1;
        idx_d         = '0;
        frame_start_d = 1'b1;
        load          = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q     <= 1'b0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
      data_sh_q     <= '0;
      dp_sh_q       <= '0;
      blank_sh_q    <= '0;
      lz_sh_q       <= 1'b0;
    end else begin
      started_q     <= started_d;
      idx_q         <= idx_d;
      frame_start_q <= frame_start_d;
      if (load) begin
        data_sh_q  <= data;
        dp_sh_q    <= dp;
        blank_sh_q <= blank;
        lz_sh_q    <= lz_suppress;
      end
    end
  end

  // Output stage: decode the current digit from the shadow and register it.
  logic [DIGITS-1:0] an_d, an_q, hot;
  logic [6:0]        seg_d, seg_q;
  logic              seg_dp_d, seg_dp_q;
  logic [3:0]        nib;
  logic              blank_cur, dp_cur, upper_nz, lz_dark, lit;

  always_comb begin
    nib       = 4'h0;
    blank_cur = 1'b0;
    dp_cur    = 1'b0;
    hot       = '0;
    upper_nz  = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx_q) begin
        nib       = data_sh_q[4*j +: 4];
        blank_cur = blank_sh_q[j];
        dp_cur    = dp_sh_q[j];
        hot[j]    = 1'b1;
      end
      // Any nonzero nibble at or above the current digit keeps it lit.
      if (IW'(j) >= idx_q && data_sh_q[4*j +: 4] != 4'h0) begin
        upper_nz = 1'b1;
      end
    end
    lz_dark  = lz_sh_q && (idx_q != '0) && !upper_nz;
    lit      = started_q && !blank_cur && !lz_dark;
    an_d     = lit ? (hot ^ AN_OFF) : AN_OFF;
    seg_d    = lit ? (hex7(nib) ^ SEG_OFF) : SEG_OFF;
    seg_dp_d = lit ? (dp_cur ^ DP_OFF) : DP_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      seg_dp_q <= DP_OFF;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           scan_clk;
  logic [4*D-1:0] data;
  logic [D-1:0]   dp, blank;
  logic           lz_suppress;
  logic [D-1:0]   an;
  logic [6:0]     seg;
  logic           seg_dp;
  logic           frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .data(data), .dp(dp),
    .blank(blank), .lz_suppress(lz_suppress), .an(an), .seg(seg),
    .seg_dp(seg_dp), .frame_start(frame_start)
  );

  int n_pass = 0;
  int n_total = 0;
  int fs_count = 0;

  always @(negedge clk) if (frame_start === 1'b1) fs_count++;

  // Reference model: which digit the display should be on and the frame snapshot.
  logic [6:0]     hex_tab [16];
  bit             m_started;
  int             m_digit;
  logic [4*D-1:0] m_data;
  logic [D-1:0]   m_dp, m_blank;
  logic           m_lz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One scan_clk rising edge: either a new frame (snapshot inputs) or next digit.
  task automatic model_tick(output int exp_fs);
    if (!m_started || m_digit == D - 1) begin
      m_started = 1'b1;
      m_digit   = 0;
      m_data    = data;
      m_dp      = dp;
      m_blank   = blank;
      m_lz      = lz_suppress;
      exp_fs    = 1;
    end else begin
      m_digit++;
      exp_fs = 0;
    end
  endtask

  task automatic check_display(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] value;
    bit         dark;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (m_started) begin
      value = 4'((m_data >> (4 * m_digit)) & 16'hF);
      dark  = m_blank[m_digit] ||
              (m_lz && m_digit != 0 && (m_data >> (4 * m_digit)) == 0);
      if (!dark) begin
        e_an  = 4'hF ^ 4'(1 << m_digit);
        e_seg = ~hex_tab[value];
        e_dp  = ~m_dp[m_digit];
      end
    end
    check({tag, ".an"}, 32'(an), 32'(e_an));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp"}, 32'(seg_dp), 32'(e_dp));
  endtask

  task automatic scan_step(input string tag);
    int fs0, exp_fs;
    fs0 = fs_count;
    @(negedge clk) scan_clk = 1'b1;
    model_tick(exp_fs);
    repeat (10) @(negedge clk);
    check_display(tag);
    check({tag, ".frame_start"}, 32'(fs_count - fs0), 32'(exp_fs));
    scan_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic random_inputs();
    data        = 16'($urandom);
    if ($urandom_range(0, 2) == 0) data = data & 16'h00FF;
    if ($urandom_range(0, 4) == 0) data = 16'h0000;
    dp          = 4'($urandom);
    blank       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    lz_suppress = 1'($urandom);
  endtask

  initial begin
    int fs0, exp_fs, guard;
    logic [3:0] held_an;
    logic [6:0] held_seg;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_started = 1'b0; m_digit = 0; m_data = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;

    // Reset state.
    reset = 1'b1; scan_clk = 1'b0;
    data = 16'h1234; dp = 4'h0; blank = 4'h0; lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.an", 32'(an), 32'h0000000F);
    check("reset.seg", 32'(seg), 32'h0000007F);
    check("reset.dp", 32'(seg_dp), 32'h1);
    check("reset.frame_start", 32'(frame_start), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_display("pre_tick");
    check("pre_tick.fs", 32'(fs_count), 32'h0);

    // Plain 1234 for two frames, then one more frame start.
    for (int k = 0; k < 8; k++) scan_step("p1234");
    check("p1234.fs_total", 32'(fs_count), 32'h2);
    scan_step("p1234_f3");
    scan_step("p1234_f3");

    // Mid-frame data change: only visible from the next frame.
    data = 16'hABCD;
    for (int k = 0; k < 6; k++) scan_step("midchg");

    // Leading zero suppression with decimal point on digit 0.
    data = 16'h0070; lz_suppress = 1'b1; dp = 4'b0001;
    for (int k = 0; k < 8; k++) scan_step("lz0070");
    data = 16'h0000;
    for (int k = 0; k < 8; k++) scan_step("lz0000");

    // Blanked digit 2.
    data = 16'h8888; lz_suppress = 1'b0; dp = 4'h0; blank = 4'b0100;
    for (int k = 0; k < 8; k++) scan_step("blank2");

    // Randomized inputs, changed after every digit step.
    for (int k = 0; k < 40; k++) begin
      random_inputs();
      scan_step("rand");
    end

    // Reset while digit 2 is displayed.
    data = 16'h5A3C; dp = 4'b0110; blank = 4'h0; lz_suppress = 1'b0;
    guard = 0;
    while ((!m_started || m_digit != 2) && guard < 8) begin
      scan_step("to_d2");
      guard++;
    end
    check("reached_d2", 32'(m_digit), 32'h2);
    @(negedge clk) reset = 1'b1;
    #1;
    m_started = 1'b0;
    check("async_reset.an", 32'(an), 32'h0000000F);
    check("async_reset.seg", 32'(seg), 32'h0000007F);
    check("async_reset.dp", 32'(seg_dp), 32'h1);
    repeat (3) @(negedge clk);
    data = 16'h9F06;
    reset = 1'b0;
    fs0 = fs_count;
    repeat (20) @(negedge clk);
    check_display("post_reset_idle");
    check("post_reset_idle.fs", 32'(fs_count - fs0), 32'h0);
    scan_step("post_reset_first");
    check("post_reset_first.digit", 32'(an), 32'h0000000E);
    for (int k = 0; k < 5; k++) scan_step("post_reset");

    // Single-clk-wide scan_clk glitch counts as exactly one edge.
    fs0 = fs_count;
    @(negedge clk) scan_clk = 1'b1;
    @(negedge clk) scan_clk = 1'b0;
    model_tick(exp_fs);
    repeat (12) @(negedge clk);
    check_display("glitch");
    check("glitch.fs", 32'(fs_count - fs0), 32'(exp_fs));
    scan_step("after_glitch");
    scan_step("after_glitch");

    // scan_clk held high: one advance, then frozen.
    fs0 = fs_count;
    @(negedge clk) scan_clk = 1'b1;
    model_tick(exp_fs);
    repeat (12) @(negedge clk);
    check_display("held_rise");
    held_an = an; held_seg = seg;
    repeat (1000) @(negedge clk);
    check_display("held_1000");
    check("held.fs", 32'(fs_count - fs0), 32'(exp_fs));
    scan_clk = 1'b0;
    repeat (12) @(negedge clk);
    check_display("held_fall");
    scan_step("after_held");
    scan_step("after_held");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
